double_stream_fifo: RTL and testbench

DOUBLE_STREAM_FIFO -- requirements
Module: double_stream_fifo

---
 rtl/double_stream_fifo_if.sv | 24 ++
 rtl/double_stream_fifo.sv | 91 +++++++++
 tb/tb_double_stream_fifo.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/double_stream_fifo_if.sv
// double_stream_fifo_if: write-side and read-side stream handshake bundle.
//   input_a / input_a_stb / input_a_ack    : upstream word, valid, accept
//   output_z / output_z_stb / output_z_ack : head word, valid, downstream accept
// master modport: the environment (producer + consumer); slave modport: the FIFO.
interface double_stream_fifo_if #(
    parameter int unsigned WIDTH = 64
);
    logic [WIDTH-1:0] input_a;
    logic             input_a_stb;
    logic             input_a_ack;
    logic [WIDTH-1:0] output_z;
    logic             output_z_stb;
    logic             output_z_ack;

    modport master (
        output input_a, input_a_stb, output_z_ack,
        input  input_a_ack, output_z, output_z_stb
    );

    modport slave (
        input  input_a, input_a_stb, output_z_ack,
        output input_a_ack, output_z, output_z_stb
    );
endinterface

// File: rtl/double_stream_fifo.sv
// double_stream_fifo: synchronous stb/ack FIFO feeding the double_adder operand port.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset (clears pointers and count, not memory)
//   bus  - double_stream_fifo_if.slave (write side input_a*, read side output_z*)
//   level - occupancy, only when FIFO_LEVEL_EN is defined
// Optional feature macro: FIFO_LEVEL_EN.
// DEPTH must be a power of two in 2..16.
module double_stream_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    double_stream_fifo_if.slave      bus
`ifdef FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ack_q, ack_d;
    logic             stb_q, stb_d;
    logic             wr_en_c;
    logic             rd_en_c;

    // Next-state: transfers, pointer advance, occupancy and handshake flags.
    // The flags are precomputed from count_d so they leave flops directly.
    always_comb begin
        wr_en_c  = bus.input_a_stb & ack_q & ~rst;
        rd_en_c  = bus.output_z_ack & stb_q & ~rst;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en_c) begin
            mem_d[wr_ptr_q] = bus.input_a;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr_en_c, rd_en_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ack_d = (count_d < CNT_W'(DEPTH));
        stb_d = (count_d != '0);
    end

    // Control state; reset wins over any same-edge transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b1;
            stb_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            stb_q    <= stb_d;
        end
    end

    // Storage is left untouched by reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.input_a_ack  = ack_q;
    assign bus.output_z_stb = stb_q;
    assign bus.output_z     = mem_q[rd_ptr_q];

`ifdef FIFO_LEVEL_EN
    assign level = count_q;
`endif
endmodule

// File: tb/tb_double_stream_fifo.sv
// tb_double_stream_fifo: directed scenarios plus a randomized stream, all checked
// against a queue-based reference of the FIFO's occupancy and word order.
module tb_double_stream_fifo;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;

    double_stream_fifo_if #(.WIDTH(WIDTH)) bus ();

`ifdef FIFO_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    double_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave)
`ifdef FIFO_LEVEL_EN
        ,
        .level(level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] model_q [$];
    int n_wr = 0;
    int n_rd = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare all outputs with the reference, drive one cycle, advance the reference.
    task automatic cycle(input bit do_rst, input bit a_stb, input logic [WIDTH-1:0] a,
                         input bit z_ack);
        bit wr;
        bit rd;
        check("z_stb", 64'(bus.output_z_stb), 64'(model_q.size() > 0));
        check("a_ack", 64'(bus.input_a_ack), 64'(model_q.size() < DEPTH));
        if (model_q.size() > 0) check("z_data", bus.output_z, model_q[0]);
`ifdef FIFO_LEVEL_EN
        check("level", 64'(level), 64'(model_q.size()));
`endif
        rst              = do_rst;
        bus.input_a_stb  = a_stb;
        bus.input_a      = a;
        bus.output_z_ack = z_ack;
        wr = a_stb && (model_q.size() < DEPTH);
        rd = z_ack && (model_q.size() > 0);
        @(posedge clk);
        if (do_rst) begin
            model_q.delete();
        end else begin
            if (rd) begin
                void'(model_q.pop_front());
                n_rd++;
            end
            if (wr) begin
                model_q.push_back(a);
                n_wr++;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] w;
        int budget;
        rst              = 1'b1;
        bus.input_a      = '0;
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state (checked inside cycle) and idle.
        cycle(0, 0, '0, 0);

        // Three writes with consumer stalled; latency of one cycle.
        cycle(0, 1, 64'h3FF0000000000000, 0);
        check("lat_stb", 64'(bus.output_z_stb), 64'd1);
        cycle(0, 1, 64'h4000000000000000, 0);
        cycle(0, 1, 64'hC008000000000000, 0);
        check("three_ack", 64'(bus.input_a_ack), 64'd1);
        check("three_cnt", 64'(model_q.size()), 64'd3);
        cycle(0, 0, '0, 0);
        while (model_q.size() > 0) cycle(0, 0, '0, 1);

        // Five writes into depth four, then drain; fifth word accepted afterwards.
        for (int i = 0; i < 5; i++) cycle(0, 1, 64'(100 + i), 0);
        check("full_ack", 64'(bus.input_a_ack), 64'd0);
        check("full_cnt", 64'(model_q.size()), 64'(DEPTH));
        for (int i = 0; i < 4; i++) begin
            check("full_order", bus.output_z, 64'(100 + i));
            cycle(0, 0, '0, 1);
        end
        cycle(0, 1, 64'd104, 0);
        check("fifth_word", bus.output_z, 64'd104);
        cycle(0, 0, '0, 1);

        // Full FIFO with producer and consumer both active for ten cycles.
        for (int i = 0; i < 4; i++) cycle(0, 1, 64'(200 + i), 0);
        budget = n_rd;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 64'(300 + i), 1);
            check("steady_lvl", 64'(model_q.size() >= 3 && model_q.size() <= 4), 64'd1);
        end
        check("steady_reads", 64'(n_rd - budget), 64'd10);
        while (model_q.size() > 0) cycle(0, 0, '0, 1);

        // Empty with consumer ready: nothing appears.
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);
        check("empty_stb", 64'(bus.output_z_stb), 64'd0);

        // Reset mid-operation drops stored words.
        cycle(0, 1, 64'hAAAA, 0);
        cycle(0, 1, 64'hBBBB, 0);
        cycle(1, 1, 64'hCCCC, 0);
        check("rst_stb", 64'(bus.output_z_stb), 64'd0);
        check("rst_ack", 64'(bus.input_a_ack), 64'd1);
        cycle(0, 1, 64'hDDDD, 0);
        check("rst_first", bus.output_z, 64'hDDDD);
        cycle(0, 0, '0, 1);

        // Randomized stream with stalling consumer and data churn while stalled.
        n_wr = 0;
        n_rd = 0;
        budget = 20000;
        while ((n_wr < 1000 || model_q.size() > 0) && budget > 0) begin
            w = rnd64();
            cycle(0, (n_wr < 1000) && ($urandom_range(0, 3) != 0), w,
                  $urandom_range(0, 1) == 1);
            budget--;
        end
        check("stream_done", 64'(budget > 0), 64'd1);
        check("stream_wr", 64'(n_wr), 64'd1000);
        check("stream_rd", 64'(n_rd), 64'd1000);
        cycle(0, 0, '0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
